// File: rtl/weight_bram_sequencer_if.sv
// Bus bundle between the weight RAM sequencer and its surroundings.
//
// Three groups of signals:
//   host load stream  : ld_valid, ld_data (to sequencer), ld_ready (from sequencer)
//   weight RAM port   : ram_addr, ram_di, ram_en, ram_we (from sequencer), ram_do (to sequencer)
//   MAC weight stream : w_valid, w_data, w_idx, w_last (from sequencer), w_ready (to sequencer)
//
// The master modport is the sequencer. The slave modport is the environment, which
// covers the host, the RAM and the MAC.
interface weight_bram_sequencer_if #(
  parameter int unsigned Aw = 5,
  parameter int unsigned Dw = 16
) ();

  logic          ld_valid;
  logic [Dw-1:0] ld_data;
  logic          ld_ready;

  logic [Aw-1:0] ram_addr;
  logic [Dw-1:0] ram_di;
  logic          ram_en;
  logic          ram_we;
  logic [Dw-1:0] ram_do;

  logic          w_valid;
  logic [Dw-1:0] w_data;
  logic [Aw-1:0] w_idx;
  logic          w_last;
  logic          w_ready;

  modport master (
    input  ld_valid, ld_data, ram_do, w_ready,
    output ld_ready, ram_addr, ram_di, ram_en, ram_we, w_valid, w_data, w_idx, w_last
  );

  modport slave (
    output ld_valid, ld_data, ram_do, w_ready,
    input  ld_ready, ram_addr, ram_di, ram_en, ram_we, w_valid, w_data, w_idx, w_last
  );

endinterface

// File: rtl/weight_bram_sequencer.sv
// Controller for one Depth x Dw weight block RAM. The RAM is synchronous and acts on the
// falling clock edge, with a one-cycle read latency as seen from the rising edge.
//
// The controller has two jobs:
//   - Load: it writes host beats into addresses 0..Depth-1 in order.
//   - Stream: it reads every word in address order and presents it to the MAC. The MAC
//     stream uses valid/ready handshaking.
//
// Ports:
//   clk       rising-edge clock for all controller logic
//   rst       synchronous, active-high reset
//   start     one-cycle pulse that starts a stream pass; only taken in idle.
//             It has priority over load.
//   load      one-cycle pulse that starts a load pass; only taken in idle
//   bus       weight_bram_sequencer_if.master. It carries the host load stream,
//             the RAM port and the MAC weight stream.
//   busy      high in every state except idle
//   done      one-cycle pulse at the end of a load or stream pass
//   checksum  (only with WEIGHT_BRAM_SEQUENCER_CHECKSUM_EN defined) the modulo-2^Dw sum
//             of the beats accepted in the current or last stream pass
//
// Optional feature macro: WEIGHT_BRAM_SEQUENCER_CHECKSUM_EN
module weight_bram_sequencer #(
  parameter int unsigned Depth = 28,
  parameter int unsigned Aw    = 5,
  parameter int unsigned Dw    = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic                           load,
  weight_bram_sequencer_if.master        bus,
  output logic                           busy,
  output logic                           done
`ifdef WEIGHT_BRAM_SEQUENCER_CHECKSUM_EN
  ,
  output logic [Dw-1:0]                  checksum
`endif
);

  // The read counter is one bit wider so that it can hold Depth without wrapping.
  localparam logic [Aw:0]   RdEnd   = (Aw+1)'(Depth);
  localparam logic [Aw-1:0] LastIdx = Aw'(Depth - 1);

  typedef enum logic [1:0] {StIdle, StLoad, StStream, StDone} state_e;

  state_e        state_q;
  logic [Aw-1:0] wr_cnt_q;
  logic [Aw:0]   rd_cnt_q;

  logic          ram_en_q;
  logic          ram_we_q;
  logic [Aw-1:0] ram_addr_q;
  logic [Dw-1:0] ram_di_q;

  logic          w_valid_q;
  logic          w_last_q;
  logic [Dw-1:0] w_data_q;
  logic [Aw-1:0] w_idx_q;

  logic          ld_ready_q;
  logic          busy_q;
  logic          done_q;

`ifdef WEIGHT_BRAM_SEQUENCER_CHECKSUM_EN
  logic [Dw-1:0] checksum_q;
`endif

  logic accept;
  logic rd_inflight;
  logic rd_issue;

  always_comb begin
    accept      = w_valid_q && bus.w_ready;
    // A read issued on the previous edge returns its data on this edge.
    rd_inflight = ram_en_q && !ram_we_q;
    // A read may only be issued if the output register is free at the next edge and
    // no other read is outstanding. This keeps the RAM output from being overwritten
    // before it has been captured.
    rd_issue    = (state_q == StStream) && (!w_valid_q || accept) && !rd_inflight &&
                  (rd_cnt_q < RdEnd);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      wr_cnt_q   <= '0;
      rd_cnt_q   <= '0;
      ram_en_q   <= 1'b0;
      ram_we_q   <= 1'b0;
      ram_addr_q <= '0;
      ram_di_q   <= '0;
      w_valid_q  <= 1'b0;
      w_last_q   <= 1'b0;
      w_data_q   <= '0;
      w_idx_q    <= '0;
      ld_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef WEIGHT_BRAM_SEQUENCER_CHECKSUM_EN
      checksum_q <= '0;
`endif
    end else begin
      // The RAM enable and done flag are single-cycle strobes unless this cycle sets them.
      ram_en_q <= 1'b0;
      ram_we_q <= 1'b0;
      done_q   <= 1'b0;

      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q   <= StStream;
            busy_q    <= 1'b1;
            rd_cnt_q  <= '0;
            w_valid_q <= 1'b0;
`ifdef WEIGHT_BRAM_SEQUENCER_CHECKSUM_EN
            checksum_q <= '0;
`endif
          end else if (load) begin
            state_q    <= StLoad;
            busy_q     <= 1'b1;
            ld_ready_q <= 1'b1;
            wr_cnt_q   <= '0;
          end
        end

        StLoad: begin
          if (bus.ld_valid) begin
            ram_en_q   <= 1'b1;
            ram_we_q   <= 1'b1;
            ram_addr_q <= wr_cnt_q;
            ram_di_q   <= bus.ld_data;
            if (wr_cnt_q == LastIdx) begin
              wr_cnt_q   <= '0;
              ld_ready_q <= 1'b0;
              state_q    <= StDone;
              done_q     <= 1'b1;
            end else begin
              wr_cnt_q <= wr_cnt_q + Aw'(1);
            end
          end
        end

        StStream: begin
          if (accept) begin
            w_valid_q <= 1'b0;
`ifdef WEIGHT_BRAM_SEQUENCER_CHECKSUM_EN
            checksum_q <= checksum_q + w_data_q;
`endif
            if (w_last_q) begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end
          end
          // Capture and accept never coincide: a read only issues when the register
          // will be empty at the edge on which its data returns.
          if (rd_inflight) begin
            w_valid_q <= 1'b1;
            w_data_q  <= bus.ram_do;
            w_idx_q   <= ram_addr_q;
            w_last_q  <= (ram_addr_q == LastIdx);
          end
          if (rd_issue) begin
            ram_en_q   <= 1'b1;
            ram_addr_q <= rd_cnt_q[Aw-1:0];
            rd_cnt_q   <= rd_cnt_q + (Aw+1)'(1);
          end
        end

        StDone: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end

        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ld_ready = ld_ready_q;
  assign bus.ram_en   = ram_en_q;
  assign bus.ram_we   = ram_we_q;
  assign bus.ram_addr = ram_addr_q;
  assign bus.ram_di   = ram_di_q;
  assign bus.w_valid  = w_valid_q;
  assign bus.w_data   = w_data_q;
  assign bus.w_idx    = w_idx_q;
  assign bus.w_last   = w_last_q;
  assign busy         = busy_q;
  assign done         = done_q;

`ifdef WEIGHT_BRAM_SEQUENCER_CHECKSUM_EN
  assign checksum = checksum_q;
`endif

endmodule

// File: doc/weight_bram_sequencer.md
Name: weight_bram_sequencer

Overview:
- Controller for one 28-entry x 16-bit weight block RAM (synchronous, reads and writes on the falling clock edge, read/write via EN/WE/ADDR/DI/DO).
- Two jobs: sequential loading of weights from a host write stream, and streaming all weights in address order to the neuron MAC with valid/ready backpressure.
- Sits between the host/loader and one weight RAM instance; the MAC consumes one weight per accepted beat.

Parameters:
- DEPTH, 28, number of weight words (valid addresses 0..DEPTH-1).
- AW, 5, address width; must satisfy 2^AW >= DEPTH.
- DW, 16, weight word width.

Ports:
- CLK  in  1  clock; all controller logic on the rising edge.
- RST  in  1  synchronous, active-high reset.
- START  in  1  one-cycle pulse: begin streaming a pass; ignored unless IDLE.
- LOAD  in  1  one-cycle pulse: begin a load pass; ignored unless IDLE; START wins if both are high.
- LD_VALID  in  1  host write beat valid (LOAD state only).
- LD_DATA  in  DW  host write data.
- LD_READY  out  1  high in LOAD state.
- RAM_ADDR  out  AW  to RAM ADDR.
- RAM_DI  out  DW  to RAM DI.
- RAM_EN  out  1  to RAM EN.
- RAM_WE  out  1  to RAM WE.
- RAM_DO  in  DW  from RAM DO.
- W_VALID  out  1  streamed weight valid.
- W_DATA  out  DW  streamed weight.
- W_IDX  out  AW  address of W_DATA.
- W_LAST  out  1  high with the beat for index DEPTH-1.
- W_READY  in  1  consumer accepts the beat when W_VALID and W_READY are both high.
- BUSY  out  1  high in any state except IDLE.
- DONE  out  1  one-cycle pulse at the end of a load or stream pass.

Behaviour:
- Reset: state IDLE; all outputs 0; address counters 0; output register empty.
- RAM port outputs are registered on the rising edge. RAM samples them on the following falling edge. RAM_DO is valid at the next rising edge (1-cycle read latency).
- States:
  - IDLE -> STREAM on START.
  - IDLE -> LOAD on LOAD and not START.
  - LOAD -> DONE_S after the write to DEPTH-1.
  - STREAM -> DONE_S when the beat with index DEPTH-1 is accepted.
  - DONE_S -> IDLE unconditionally. DONE=1 for exactly this one cycle.
- LOAD:
  - Each cycle with LD_VALID=1: drive RAM_EN=1, RAM_WE=1, RAM_ADDR=wr_cnt, RAM_DI=LD_DATA, then wr_cnt++.
  - Cycles with LD_VALID=0: RAM_EN=0.
  - The write at wr_cnt=DEPTH-1 ends the pass; wr_cnt returns to 0.
- STREAM:
  - Read issue: RAM_EN=1, RAM_WE=0, RAM_ADDR=rd_cnt.
  - A read may issue only if the output register will be free at the next edge: the register is empty, or it is being accepted this cycle, and no read is already in flight.
  - This gives at most one read in flight and no skid overflow. The RAM DO register is never overwritten before its data is captured.
  - The returned word is loaded into W_DATA/W_IDX/W_LAST with W_VALID=1.
  - W_DATA, W_IDX and W_LAST hold stable while W_VALID=1 and W_READY=0.
  - No reads are issued past DEPTH-1; rd_cnt does not wrap within a pass.
- Throughput with W_READY held at 1: one beat every 2 cycles. First W_VALID rises 2 cycles after the START edge.
- Boundaries:
  - START or LOAD while BUSY: ignored, no side effects.
  - W_READY deasserted on the W_LAST beat: remain in STREAM until it is accepted.
  - RST mid-pass: immediate return to IDLE. RAM_EN drops the same edge. Any in-flight read is discarded. A partial load leaves RAM contents at the written addresses only.
  - RAM_EN=0 whenever no read or write is being issued.

Optional Feature:
- Macro: WEIGHT_BRAM_SEQUENCER_CHECKSUM_EN.
- When defined, adds output CHECKSUM (DW bits): the modulo-2^DW sum of all beats accepted in the current/last stream pass.
  - Cleared to 0 on RST and on START acceptance.
  - Updated on each accepted beat; stable from DONE until the next START.
- When not defined, the port and its logic are absent; behaviour is otherwise identical.

Test Plan:
- Reset: assert RST 3 cycles mid-STREAM -> all outputs 0, state IDLE, no RAM_EN in the following cycle.
- Load: LOAD, then 28 beats LD_DATA=0x0100+i with LD_VALID gapped every 3rd cycle -> writes at addresses 0..27 in order, DONE one cycle after the last write, BUSY low next.
- Stream, no backpressure: START with W_READY=1 -> beats W_IDX 0..27 carry W_DATA 0x0100..0x011B, W_LAST only on idx 27, first W_VALID 2 cycles after START, DONE after the idx-27 acceptance.
- Backpressure: W_READY=0 for 5 cycles at idx 10 -> W_DATA holds 0x010A, no RAM_EN pulses during the stall, idx 11 follows after release, no word lost or duplicated.
- Collisions: START and LOAD in the same cycle -> STREAM entered. START pulse during STREAM -> ignored, exactly 28 beats.
- Checksum (macro on): stream of the load-test data -> CHECKSUM = 0x1C00 + 378 = 0x1D7A at DONE. Second START clears it to 0 before the first beat.
